exibicao_bcd_7seg: RTL

EXIBICAO_BCD_7SEG -- requirements
Module: exibicao_bcd_7seg

---
 rtl/exibicao_bcd_7seg_pkg.sv | 60 ++++++
 rtl/exibicao_bcd_7seg_decodificador_7seg.sv | 35 +++
 rtl/exibicao_bcd_7seg.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/exibicao_bcd_7seg_pkg.sv
// ---------------------------------------------------------------------------
// pacote_exibicao
// Shared definitions for the BCD / seven-segment display block:
//   - estado_t       : conversion FSM states (IDLE, CONV, FIM)
//   - N_ITERACOES    : number of double-dabble steps (one per magnitude bit)
//   - SEG_*          : active-low segment patterns, bit6=g ... bit0=a
//   - COD_*          : glyph codes fed to decodificador_7seg (0-9 are digits)
//   - passo_dabble() : one add-3-then-shift step over {bcd[11:0], mag[7:0]}
// ---------------------------------------------------------------------------
package pacote_exibicao;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIM  = 2'd2
    } estado_t;

    localparam int         N_ITERACOES = 8;
    localparam logic [3:0] ULTIMA_ITER = 4'(N_ITERACOES - 1);

    // Digit patterns
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Letter / symbol patterns
    localparam logic [6:0] SEG_E       = 7'b0000110;
    localparam logic [6:0] SEG_R       = 7'b0101111;
    localparam logic [6:0] SEG_O       = 7'b0100011;
    localparam logic [6:0] SEG_TRACO   = 7'b0111111;
    localparam logic [6:0] SEG_APAGADO = 7'b1111111;

    // Glyph codes above the decimal range
    localparam logic [3:0] COD_TRACO   = 4'hA;
    localparam logic [3:0] COD_APAGADO = 4'hB;
    localparam logic [3:0] COD_E       = 4'hC;
    localparam logic [3:0] COD_R       = 4'hD;
    localparam logic [3:0] COD_O       = 4'hE;

    // One double-dabble step: bits [19:8] hold hundreds:tens:units,
    // bits [7:0] hold the remaining magnitude, MSB first.
    function automatic logic [19:0] passo_dabble(input logic [19:0] trab);
        logic [19:0] ajustado;
        ajustado = trab;
        for (int i = 0; i < 3; i++) begin
            if (ajustado[8 + 4*i +: 4] >= 4'd5) begin
                ajustado[8 + 4*i +: 4] = ajustado[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {ajustado[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/exibicao_bcd_7seg_decodificador_7seg.sv
// ---------------------------------------------------------------------------
// decodificador_7seg
// Combinational glyph decoder for one display position.
//   codigo    in  4  0-9 = decimal digit, COD_* = symbol / letter / blank
//   segmentos out 7  active-low pattern, bit6=g ... bit0=a
// ---------------------------------------------------------------------------
module decodificador_7seg
    import pacote_exibicao::*;
(
    input  logic [3:0] codigo,
    output logic [6:0] segmentos
);

    always_comb begin
        segmentos = SEG_APAGADO;
        case (codigo)
            4'd0:      segmentos = SEG_0;
            4'd1:      segmentos = SEG_1;
            4'd2:      segmentos = SEG_2;
            4'd3:      segmentos = SEG_3;
            4'd4:      segmentos = SEG_4;
            4'd5:      segmentos = SEG_5;
            4'd6:      segmentos = SEG_6;
            4'd7:      segmentos = SEG_7;
            4'd8:      segmentos = SEG_8;
            4'd9:      segmentos = SEG_9;
            COD_TRACO: segmentos = SEG_TRACO;
            COD_E:     segmentos = SEG_E;
            COD_R:     segmentos = SEG_R;
            COD_O:     segmentos = SEG_O;
            default:   segmentos = SEG_APAGADO;
        endcase
    end

endmodule

// File: rtl/exibicao_bcd_7seg.sv
// ---------------------------------------------------------------------------
// exibicao_bcd_7seg
// Converts an 8-bit calculator value (unsigned or two's complement) into
// BCD with a sequential double-dabble and drives four seven-segment digits.
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous reset, active-low
//   valor      in   8   value to display
//   modo_sinal in   1   1 = valor is two's complement, 0 = unsigned
//   erro       in   1   error flag, display shows "Erro"
//   hex3..hex0 out  7   active-low segment patterns (hex3 = leftmost)
//   bcd        out 12   last converted magnitude, hundreds:tens:units
//   ocupado    out  1   high while a conversion is in progress
//   pronto     out  1   one-cycle pulse when outputs are updated
// ---------------------------------------------------------------------------
module exibicao_bcd_7seg
    import pacote_exibicao::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  valor,
    input  logic        modo_sinal,
    input  logic        erro,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic [11:0] bcd,
    output logic        ocupado,
    output logic        pronto
);

    estado_t     estado_reg, estado_next;
    logic [7:0]  snap_valor_reg, snap_valor_next;
    logic        snap_modo_reg, snap_modo_next;
    logic        snap_erro_reg, snap_erro_next;
    logic        neg_reg, neg_next;
    logic [19:0] trab_reg, trab_next;
    logic [3:0]  iter_reg, iter_next;
    logic [11:0] bcd_reg, bcd_next;
    logic [6:0]  hex_reg [4];
    logic [6:0]  hex_next [4];
    logic        pronto_reg, pronto_next;

    logic        mudou;
    logic        negativo;
    logic [7:0]  magnitude;
    logic [3:0]  centena, dezena, unidade;
    logic [3:0]  codigo [4];
    logic [6:0]  seg_dec [4];

    // Live-input evaluation used only when a conversion is launched.
    always_comb begin
        mudou     = ({valor, modo_sinal, erro} != {snap_valor_reg, snap_modo_reg, snap_erro_reg});
        negativo  = modo_sinal & valor[7];
        // 0x80 negates to 0x80, which read as unsigned is the required 128.
        magnitude = negativo ? 8'(~valor + 8'd1) : valor;
    end

    // Glyph selection for each position from the finished conversion.
    always_comb begin
        centena = trab_reg[19:16];
        dezena  = trab_reg[15:12];
        unidade = trab_reg[11:8];
        if (snap_erro_reg) begin
            codigo[3] = COD_E;
            codigo[2] = COD_R;
            codigo[1] = COD_R;
            codigo[0] = COD_O;
        end else begin
            codigo[3] = neg_reg ? COD_TRACO : COD_APAGADO;
            codigo[2] = (centena == 4'd0) ? COD_APAGADO : centena;
            codigo[1] = ((centena == 4'd0) && (dezena == 4'd0)) ? COD_APAGADO : dezena;
            codigo[0] = unidade;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digito
            decodificador_7seg u_dec (
                .codigo    (codigo[gi]),
                .segmentos (seg_dec[gi])
            );
        end
    endgenerate

    // Next-state and datapath
    always_comb begin
        estado_next     = estado_reg;
        snap_valor_next = snap_valor_reg;
        snap_modo_next  = snap_modo_reg;
        snap_erro_next  = snap_erro_reg;
        neg_next        = neg_reg;
        trab_next       = trab_reg;
        iter_next       = iter_reg;
        bcd_next        = bcd_reg;
        hex_next        = hex_reg;
        pronto_next     = 1'b0;

        case (estado_reg)
            IDLE: begin
                if (mudou) begin
                    snap_valor_next = valor;
                    snap_modo_next  = modo_sinal;
                    snap_erro_next  = erro;
                    neg_next        = negativo;
                    trab_next       = {12'd0, magnitude};
                    iter_next       = 4'd0;
                    estado_next     = CONV;
                end
            end
            CONV: begin
                trab_next = passo_dabble(trab_reg);
                iter_next = iter_reg + 4'd1;
                if (iter_reg == ULTIMA_ITER) begin
                    estado_next = FIM;
                end
            end
            FIM: begin
                bcd_next = trab_reg[19:8];
                for (int i = 0; i < 4; i++) begin
                    hex_next[i] = seg_dec[i];
                end
                pronto_next = 1'b1;
                estado_next = IDLE;
            end
            default: begin
                estado_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg     <= IDLE;
            snap_valor_reg <= 8'd0;
            snap_modo_reg  <= 1'b0;
            snap_erro_reg  <= 1'b0;
            neg_reg        <= 1'b0;
            trab_reg       <= 20'd0;
            iter_reg       <= 4'd0;
            bcd_reg        <= 12'd0;
            hex_reg[0]     <= SEG_0;
            hex_reg[1]     <= SEG_APAGADO;
            hex_reg[2]     <= SEG_APAGADO;
            hex_reg[3]     <= SEG_APAGADO;
            pronto_reg     <= 1'b0;
        end else begin
            estado_reg     <= estado_next;
            snap_valor_reg <= snap_valor_next;
            snap_modo_reg  <= snap_modo_next;
            snap_erro_reg  <= snap_erro_next;
            neg_reg        <= neg_next;
            trab_reg       <= trab_next;
            iter_reg       <= iter_next;
            bcd_reg        <= bcd_next;
            hex_reg        <= hex_next;
            pronto_reg     <= pronto_next;
        end
    end

    assign hex0    = hex_reg[0];
    assign hex1    = hex_reg[1];
    assign hex2    = hex_reg[2];
    assign hex3    = hex_reg[3];
    assign bcd     = bcd_reg;
    assign pronto  = pronto_reg;
    assign ocupado = (estado_reg != IDLE);

endmodule
